// File: rtl/pixel_pkg.sv
// Shared types and helpers for packing 1/2/4/8 bpp pixels LSB-first into bytes.
package pixel_pkg;

   typedef logic [1:0] bpp_log2_t;

   function automatic logic [7:0] bpp_mask(bpp_log2_t l2);
      logic [7:0] m;
      case (l2)
         2'd0:    m = 8'h01;
         2'd1:    m = 8'h03;
         2'd2:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   function automatic logic [7:0] insert_pixel(logic [7:0] acc, logic [7:0] pixel,
                                               logic [2:0] bit_pos, bpp_log2_t l2);
      return acc | ((pixel & bpp_mask(l2)) << bit_pos);
   endfunction

endpackage

// File: rtl/write_channel.sv
// Byte-RAM write strobe bundle: addr/data/enable, one-cycle enable, no backpressure.
interface WriteChannel #(parameter int ADDR_SIZE = 11);

   logic [ADDR_SIZE-1:0] addr;
   logic [7:0]           data;
   logic                 enable;

   modport Master (output addr, data, enable);
   modport Slave  (input  addr, data, enable);

endinterface

// File: rtl/pixel_packer.sv
// Packs a valid/ready pixel stream into bytes and emits one registered RAM write per byte.
module pixel_packer
   import pixel_pkg::*;
#(
   parameter int ADDR_SIZE  = 11,
   parameter int DATA_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ADDR_SIZE-1:0] base_addr,
   input  bpp_log2_t            bpp_log2,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [7:0]           in_pixel,
   input  logic                 in_last,
   WriteChannel.Master          wr,
   output logic                 busy,
   output logic                 done
);

   if (DATA_WIDTH != 8) begin : g_width_check
      $error("pixel_packer: only DATA_WIDTH == 8 is supported");
   end

   typedef enum logic {S_IDLE, S_PACK} state_t;

   state_t               r_state;
   bpp_log2_t            r_bpp;
   logic [ADDR_SIZE-1:0] r_addr;
   logic [7:0]           r_acc;
   logic [2:0]           r_bit_pos;
   logic [ADDR_SIZE-1:0] r_wr_addr;
   logic [7:0]           r_wr_data;
   logic                 r_wr_en;
   logic                 r_done;

   logic [3:0]           w_bpp;
   logic                 w_full;
   logic [7:0]           w_word;
   logic                 w_accept;

   assign in_ready  = (r_state == S_PACK);
   assign busy      = in_ready;
   assign done      = r_done;
   assign wr.addr   = r_wr_addr;
   assign wr.data   = r_wr_data;
   assign wr.enable = r_wr_en;

   assign w_bpp    = 4'd1 << r_bpp;
   assign w_full   = (({1'b0, r_bit_pos} + w_bpp) == 4'd8);
   assign w_word   = insert_pixel(r_acc, in_pixel, r_bit_pos, r_bpp);
   assign w_accept = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_bpp     <= '0;
         r_addr    <= '0;
         r_acc     <= '0;
         r_bit_pos <= '0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_wr_en   <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state   <= S_PACK;
                  r_addr    <= base_addr;
                  r_bpp     <= bpp_log2;
                  r_acc     <= '0;
                  r_bit_pos <= '0;
               end
            end
            default: begin
               if (w_accept) begin
                  // A short final byte is flushed as-is; unfilled high bits stay zero.
                  if (w_full || in_last) begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= r_addr;
                     r_wr_data <= w_word;
                     r_addr    <= r_addr + 1'b1;
                     r_acc     <= '0;
                     r_bit_pos <= '0;
                  end else begin
                     r_acc     <= w_word;
                     r_bit_pos <= r_bit_pos + w_bpp[2:0];
                  end
                  if (in_last) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer: per-cycle vector table plus random-gap and async-reset sequences.
module tb_pixel_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [10:0] base_addr = '0;
   logic [1:0]  bpp_log2 = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_pixel = '0;
   logic        in_last = 1'b0;
   logic        busy;
   logic        done;

   WriteChannel #(.ADDR_SIZE(11)) wr_if ();

   pixel_packer #(.ADDR_SIZE(11), .DATA_WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .bpp_log2  (bpp_log2),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pixel  (in_pixel),
      .in_last   (in_last),
      .wr        (wr_if),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic [10:0] base;
      logic [1:0]  bpp;
      logic        valid;
      logic [7:0]  pix;
      logic        last;
      logic        e_rdy;
      logic        e_en;
      logic [10:0] e_addr;
      logic [7:0]  e_data;
      logic        e_done;
   } vec_t;

   vec_t vq[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Start a run: packer is in PACK afterwards.
   function automatic vec_t S(input logic [10:0] b, input logic [1:0] l2);
      return '{1'b1, b, l2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 11'h0, 8'h00, 1'b0};
   endfunction
   // Pixel beat; base/bpp inputs deliberately disturbed to prove they are ignored mid-run.
   function automatic vec_t P(input logic [7:0] px, input logic lst, input logic en,
                              input logic [10:0] a, input logic [7:0] d);
      return '{1'b0, 11'h3AA, 2'd0, 1'b1, px, lst, !lst, en, a, d, lst};
   endfunction
   function automatic vec_t G();
      return '{1'b0, 11'h000, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 11'h0, 8'h00, 1'b0};
   endfunction
   function automatic vec_t SP();
      return '{1'b1, 11'h123, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 11'h0, 8'h00, 1'b0};
   endfunction
   function automatic vec_t I();
      return '{1'b0, 11'h000, 2'd0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 11'h0, 8'h00, 1'b0};
   endfunction

   task automatic drive_idle();
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_pixel = '0;
   endtask

   logic [10:0] exp_a [2];
   logic [7:0]  exp_d [2];

   initial begin
      // Reset state
      #1;
      chk("rst_en", wr_if.enable, 0);
      chk("rst_rdy", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", wr_if.addr, 0);
      chk("rst_data", wr_if.data, 0);
      @(negedge clk);
      rst_n = 1'b1;

      vq.push_back(I());
      vq.push_back(S(11'h010, 2'd3));
      vq.push_back(P(8'h11, 0, 1, 11'h010, 8'h11));
      vq.push_back(P(8'h22, 0, 1, 11'h011, 8'h22));
      vq.push_back(P(8'h33, 1, 1, 11'h012, 8'h33));
      vq.push_back(S(11'h020, 2'd0));
      vq.push_back(P(8'h01, 0, 0, 0, 0));
      vq.push_back(P(8'h00, 0, 0, 0, 0));
      vq.push_back(P(8'h01, 0, 0, 0, 0));
      vq.push_back(G());
      vq.push_back(P(8'h01, 0, 0, 0, 0));
      vq.push_back(P(8'h00, 0, 0, 0, 0));
      vq.push_back(SP());
      vq.push_back(P(8'h00, 0, 0, 0, 0));
      vq.push_back(P(8'h00, 0, 0, 0, 0));
      vq.push_back(P(8'h01, 0, 1, 11'h020, 8'h8D));
      vq.push_back(P(8'h01, 1, 1, 11'h021, 8'h01));
      vq.push_back(S(11'h030, 2'd1));
      vq.push_back(P(8'h03, 0, 0, 0, 0));
      vq.push_back(P(8'h01, 0, 0, 0, 0));
      vq.push_back(P(8'h02, 1, 1, 11'h030, 8'h27));
      vq.push_back(I());
      vq.push_back(S(11'h040, 2'd2));
      vq.push_back(P(8'hFA, 0, 0, 0, 0));
      vq.push_back(P(8'h05, 0, 1, 11'h040, 8'h5A));
      vq.push_back(P(8'hF3, 1, 1, 11'h041, 8'h03));
      vq.push_back(S(11'h7FF, 2'd3));
      vq.push_back(P(8'hAB, 0, 1, 11'h7FF, 8'hAB));
      vq.push_back(G());
      vq.push_back(P(8'hCD, 1, 1, 11'h000, 8'hCD));

      foreach (vq[i]) begin
         @(negedge clk);
         start = vq[i].start; base_addr = vq[i].base; bpp_log2 = vq[i].bpp;
         in_valid = vq[i].valid; in_pixel = vq[i].pix; in_last = vq[i].last;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_rdy", i), in_ready, vq[i].e_rdy);
         chk($sformatf("v%0d_busy", i), busy, vq[i].e_rdy);
         chk($sformatf("v%0d_en", i), wr_if.enable, vq[i].e_en);
         chk($sformatf("v%0d_done", i), done, vq[i].e_done);
         if (vq[i].e_en) begin
            chk($sformatf("v%0d_addr", i), wr_if.addr, vq[i].e_addr);
            chk($sformatf("v%0d_data", i), wr_if.data, vq[i].e_data);
         end
      end
      @(negedge clk);
      drive_idle();

      // Wrap-around run with random in_valid gaps
      begin
         int  wi = 0;
         int  pi = 0;
         bit  acc;
         bit  done_seen = 0;
         exp_a[0] = 11'h7FF; exp_a[1] = 11'h000;
         exp_d[0] = 8'hAB;   exp_d[1] = 8'hCD;
         @(negedge clk);
         start = 1'b1; base_addr = 11'h7FF; bpp_log2 = 2'd3;
         @(negedge clk);
         start = 1'b0;
         for (int c = 0; c < 200 && !done_seen; c++) begin
            if (pi < 2 && $urandom_range(0, 2) != 0) begin
               in_valid = 1'b1;
               in_pixel = (pi == 0) ? 8'hAB : 8'hCD;
               in_last  = (pi == 1);
            end else begin
               in_valid = 1'b0;
               in_last  = 1'b0;
            end
            bpp_log2 = 2'($urandom_range(0, 3));
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) pi++;
            if (wr_if.enable) begin
               if (wi < 2) begin
                  chk($sformatf("rnd_addr%0d", wi), wr_if.addr, exp_a[wi]);
                  chk($sformatf("rnd_data%0d", wi), wr_if.data, exp_d[wi]);
               end
               wi++;
            end
            if (done) done_seen = 1;
            @(negedge clk);
         end
         chk("rnd_writes", wi, 2);
         chk("rnd_done", done_seen, 1);
         drive_idle();
      end

      // Asynchronous reset mid-run, then a fresh run
      @(negedge clk);
      start = 1'b1; base_addr = 11'h050; bpp_log2 = 2'd1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         start = 1'b0; in_valid = 1'b1; in_pixel = 8'h03; in_last = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_en", wr_if.enable, 0);
      chk("ar_rdy", in_ready, 0);
      chk("ar_busy", busy, 0);
      chk("ar_done", done, 0);
      chk("ar_addr", wr_if.addr, 0);
      chk("ar_data", wr_if.data, 0);
      in_valid = 1'b1; in_last = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("ar_hold_en", wr_if.enable, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ar_post_en", wr_if.enable, 0);
      chk("ar_post_rdy", in_ready, 0);
      @(negedge clk);
      drive_idle();
      start = 1'b1; base_addr = 11'h060; bpp_log2 = 2'd3;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_pixel = 8'h5C; in_last = 1'b1;
      @(posedge clk);
      #1;
      chk("nr_en", wr_if.enable, 1);
      chk("nr_addr", wr_if.addr, 11'h060);
      chk("nr_data", wr_if.data, 8'h5C);
      chk("nr_done", done, 1);
      @(negedge clk);
      drive_idle();
      @(posedge clk);
      #1;
      chk("nr_en_off", wr_if.enable, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
